// File: rtl/div_pkg.sv
// Shared types and helpers for the programmable dual-modulus divider.
package div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int M_MIN_DEF = 2;

    // Number of high cycles in a period of ratio m: ceil(m/2).
    function automatic int unsigned calc_high(input int unsigned m);
        return (m + 1) >> 1;
    endfunction

endpackage

// File: rtl/div_mod_cnt.sv
// Modulo counter: synchronous clear, increment, and terminal-count flag.
module div_mod_cnt #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == last);

endmodule

// File: rtl/div_dm_prog.sv
// Programmable dual-modulus clock divider: divides clk by div_n+mc, near-50% duty,
// with a registered end-of-period strobe for glitch-free ratio updates.
module div_dm_prog
    import div_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter logic RST_VALUE = 1'b0,
    parameter int   M_MIN     = M_MIN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_n,
    input  logic             mc,
    output logic             fout,
    output logic             period_end,
    output logic             busy
);

    localparam int MW = WIDTH + 1;
    localparam logic [MW-1:0] M_MIN_W = MW'(M_MIN);

    state_e          state_q, state_d;
    logic [MW-1:0]   m_lat_q, m_lat_d;
    logic            fout_q, fout_d;
    logic            pe_q, pe_d;
    logic            busy_q, busy_d;

    logic [MW-1:0]   m_req;
    logic [MW-1:0]   m_sel;
    logic [MW-1:0]   m_last;
    logic [MW-1:0]   high_cnt;
    logic [MW-1:0]   cnt;
    logic [MW-1:0]   cnt_plus;
    logic            cnt_load;
    logic            cnt_inc;
    logic            cnt_tc;

    // Widened add so div_n = 2^WIDTH-1 with mc = 1 yields 2^WIDTH without wrap.
    assign m_req    = MW'(div_n) + MW'(mc);
    assign m_sel    = (m_req < M_MIN_W) ? M_MIN_W : m_req;
    assign m_last   = m_lat_q - MW'(1);
    assign high_cnt = MW'(calc_high(32'(m_lat_q)));
    assign cnt_plus = cnt + MW'(1);

    div_mod_cnt #(.W(MW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .last  (m_last),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    // Outputs are computed one cycle ahead so they line up with the counter value.
    always_comb begin
        state_d  = state_q;
        m_lat_d  = m_lat_q;
        fout_d   = fout_q;
        pe_d     = pe_q;
        busy_d   = busy_q;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d  = RUN;
                    m_lat_d  = m_sel;
                    cnt_load = 1'b1;
                    fout_d   = 1'b1;
                    pe_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                if (cnt_tc) begin
                    cnt_load = 1'b1;
                    pe_d     = 1'b0;
                    if (en) begin
                        m_lat_d = m_sel;
                        fout_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        fout_d  = RST_VALUE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_inc = 1'b1;
                    fout_d  = (cnt_plus < high_cnt);
                    pe_d    = (cnt_plus == m_last);
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_load = 1'b1;
                fout_d   = RST_VALUE;
                pe_d     = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_lat_q <= M_MIN_W;
            fout_q  <= RST_VALUE;
            pe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_lat_q <= m_lat_d;
            fout_q  <= fout_d;
            pe_q    <= pe_d;
            busy_q  <= busy_d;
        end
    end

    assign fout       = fout_q;
    assign period_end = pe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_div_dm_prog.sv
// Bench for div_dm_prog: per-cycle vector table with a scoreboard queue,
// plus hand-written enable/reset sequences.
module tb_div_dm_prog;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] div_n;
    logic       mc;
    logic       fout;
    logic       period_end;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         tag;
        logic       en;
        logic [7:0] dn;
        logic       mc;
        logic       fout;
        logic       pe;
        logic       busy;
    } vec_t;

    typedef struct {
        int   tag;
        logic fout;
        logic pe;
        logic busy;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    div_dm_prog #(.WIDTH(8), .RST_VALUE(1'b0), .M_MIN(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_n      (div_n),
        .mc         (mc),
        .fout       (fout),
        .period_end (period_end),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // One full period: the first vector carries the ratio latched at the boundary,
    // the rest carry random en/div_n/mc that the divider must ignore.
    task automatic add_period(input int tag, input logic [7:0] dn, input logic mcv);
        int m;
        int h;
        vec_t v;
        m = int'(dn) + int'(mcv);
        if (m < 2) m = 2;
        h = (m + 1) / 2;
        for (int k = 0; k < m; k++) begin
            v.tag  = tag;
            v.en   = (k == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            v.dn   = (k == 0) ? dn : 8'($urandom_range(255, 0));
            v.mc   = (k == 0) ? mcv : 1'($urandom_range(1, 0));
            v.fout = (k < h);
            v.pe   = (k == m - 1);
            v.busy = 1'b1;
            vecs.push_back(v);
        end
    endtask

    task automatic add_idle(input int tag, input int n);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.tag  = tag;
            v.en   = 1'b0;
            v.dn   = 8'($urandom_range(255, 0));
            v.mc   = 1'($urandom_range(1, 0));
            v.fout = 1'b0;
            v.pe   = 1'b0;
            v.busy = 1'b0;
            vecs.push_back(v);
        end
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b1;
        en    = 1'b0;
        div_n = 8'd0;
        mc    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_fout", fout, 1'b0);
        check("reset_pe", period_end, 1'b0);
        check("reset_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Tag 1: basic M=4. Tag 2: M=5 then alternating mc.
        for (int i = 0; i < 3; i++) add_period(1, 8'd4, 1'b0);
        add_period(2, 8'd4, 1'b1);
        add_period(2, 8'd4, 1'b1);
        for (int i = 0; i < 4; i++) add_period(2, 8'd4, 1'(i % 2 == 0));
        // Tag 3: 6 then 3 (mid-period inputs scrambled); clamp cases.
        add_period(3, 8'd6, 1'b0);
        add_period(3, 8'd3, 1'b0);
        add_period(3, 8'd0, 1'b0);
        add_period(3, 8'd1, 1'b0);
        add_period(3, 8'd1, 1'b1);
        add_period(3, 8'd2, 1'b1);
        // Tag 4: maximum ratio 256.
        add_period(4, 8'd255, 1'b1);
        // Tag 5: drop en after an M=4 period, idle, re-enable.
        add_period(5, 8'd4, 1'b0);
        add_idle(5, 3);
        add_period(5, 8'd4, 1'b0);
        // Tag 6: random small ratios.
        for (int i = 0; i < 6; i++)
            add_period(6, 8'($urandom_range(12, 0)), 1'($urandom_range(1, 0)));
        add_idle(6, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            en    = vecs[i].en;
            div_n = vecs[i].dn;
            mc    = vecs[i].mc;
            sb.push_back('{tag: vecs[i].tag, fout: vecs[i].fout,
                           pe: vecs[i].pe, busy: vecs[i].busy});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            $display("vec %0d tag %0d en=%b dn=%0d mc=%b -> fout=%b pe=%b busy=%b (exp %b %b %b)",
                     i, e.tag, vecs[i].en, vecs[i].dn, vecs[i].mc,
                     fout, period_end, busy, e.fout, e.pe, e.busy);
            check($sformatf("t%0d_fout", e.tag), fout, e.fout);
            check($sformatf("t%0d_pe", e.tag), period_end, e.pe);
            check($sformatf("t%0d_busy", e.tag), busy, e.busy);
        end

        // Asynchronous reset mid-period of an M=6 run.
        @(negedge clk);
        en    = 1'b1;
        div_n = 8'd6;
        mc    = 1'b0;
        @(posedge clk);
        #1;
        check("mid_run_busy", busy, 1'b1);
        check("mid_run_fout", fout, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-period -> fout=%b pe=%b busy=%b", fout, period_end, busy);
        check("arst_fout", fout, 1'b0);
        check("arst_pe", period_end, 1'b0);
        check("arst_busy", busy, 1'b0);

        // Release with en low: stays idle; then en high starts a period.
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle_busy", busy, 1'b0);
        check("post_rst_idle_fout", fout, 1'b0);
        @(negedge clk);
        en    = 1'b1;
        div_n = 8'd3;
        @(posedge clk);
        #1;
        $display("re-enable after reset -> fout=%b pe=%b busy=%b", fout, period_end, busy);
        check("reen_fout", fout, 1'b1);
        check("reen_busy", busy, 1'b1);
        check("reen_pe", period_end, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
